// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and helpers for the bit-serial adder controller.
//   state_e    : controller states IDLE / RUN / DONE
//   cnt_width(): bit counter width for a given operand width
//   MAX_WIDTH  : upper bound of the legal WIDTH range
package serial_add_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // One spare bit over clog2 so WIDTH-1 always fits, including WIDTH=1.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: operand / result handshakes of the bit-serial adder.
//   in_valid/in_ready + a, b, cin     : operand request
//   out_valid/out_ready + sum, cout   : result response
//   busy                              : controller in RUN or DONE
//   ovf (SERIAL_ADD_OVF_EN only)      : signed overflow of the result
// master = requester / consumer, slave = serial_add_ctrl.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;

    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout, busy, ovf);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, busy, ovf);
`else
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout, busy);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, busy);
`endif

endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// fa_cell: purely combinational 1-bit full adder.
//   i_a, i_b, i_cin : addend bits and carry in
//   o_sum, o_cout   : sum bit and carry out
module fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder reusing one fa_cell, LSB first.
// Operands are accepted on the in_* handshake, processed one bit per clock
// for WIDTH clocks, and the result is offered on the out_* handshake.
//   clk  : system clock (rising edge)
//   rst  : synchronous active-high reset
//   bus  : serial_add_ctrl_if.slave (operands, result, busy)
// Optional: define SERIAL_ADD_OVF_EN to add the bus.ovf signed-overflow output.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_add_ctrl_if.slave   bus
);

    localparam int                CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("serial_add_ctrl: WIDTH out of range 1..%0d", MAX_WIDTH);
        end
    endgenerate

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_sum_sr;
    logic [WIDTH-1:0]   w_sum_sr_nxt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_s;
    logic               w_c;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_busy;

    fa_cell u_fa (
        .i_a    (r_a_sr[0]),
        .i_b    (r_b_sr[0]),
        .i_cin  (r_carry),
        .o_sum  (w_s),
        .o_cout (w_c)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign w_sum_sr_nxt = w_s;
        end else begin : g_sum_wn
            assign w_sum_sr_nxt = {w_s, r_sum_sr[WIDTH-1:1]};
        end
    endgenerate

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)   w_state_nxt = RUN;
            RUN:     if (r_cnt == LAST)  w_state_nxt = DONE;
            DONE:    if (bus.out_ready)  w_state_nxt = IDLE;
            default:                     w_state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs (state decode only) ----------------
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            IDLE:    w_in_ready  = 1'b1;
            RUN:     w_busy      = 1'b1;
            DONE:    begin
                         w_out_valid = 1'b1;
                         w_busy      = 1'b1;
                     end
            default: w_in_ready  = 1'b0;
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;

    // ---------------- datapath ----------------
    // r_sum / r_cout are separate from the working registers so the previous
    // result stays visible while the next operation runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a_sr   <= bus.a;
                        r_b_sr   <= bus.b;
                        r_carry  <= bus.cin;
                        r_cnt    <= '0;
                        r_sum_sr <= '0;
                    end
                end
                RUN: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_sum_sr <= w_sum_sr_nxt;
                    r_carry  <= w_c;
                    if (r_cnt == LAST) begin
                        r_sum  <= w_sum_sr_nxt;
                        r_cout <= w_c;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // On the last RUN edge r_carry is the carry into the MSB and w_c the
    // carry out of it; their XOR is two's-complement overflow.
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst)                                  r_ovf <= 1'b0;
        else if (r_state == RUN && r_cnt == LAST) r_ovf <= r_carry ^ w_c;
    end

    assign bus.ovf = r_ovf;
`endif

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial N-bit adder controller built around a single 1-bit full-adder cell.
- Accepts an operand pair over a valid/ready handshake and feeds the cell one bit per clock, LSB first.
- Registers the carry between bits and assembles the result in a shift register.
- Presents the result over a second valid/ready handshake. Used wherever area beats latency; the 1-bit cell is reused unchanged.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair presented
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry into bit 0
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result bits
- cout  output  1  carry out of bit WIDTH-1
- busy  output  1  high in RUN or DONE

Behaviour:
- Single clock. Reset is synchronous and active-high; rst is sampled on the rising clk edge and overrides all other inputs.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, internal carry=0, bit counter=0.
- FSM states are IDLE, RUN and DONE.
  - IDLE: in_ready=1. On an edge with in_valid=1, latch a into shift register A_SR, b into B_SR and cin into carry reg; clear counter and sum_sr; go to RUN.
  - RUN: in_ready=0, busy=1. Each edge, the cell sees A_SR[0], B_SR[0] and carry. Its s shifts into sum_sr MSB-first (right shift), its c loads into carry, A_SR and B_SR shift right, and the counter increments. On the edge where counter==WIDTH-1, go to DONE.
  - DONE: out_valid=1. sum=sum_sr and cout=carry, both held stable. On an edge with out_ready=1, go to IDLE and clear out_valid. sum and cout keep their last value until the next result.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge. Throughput is one operation per WIDTH+2 cycles with out_ready tied high.
- in_ready is a pure decode of state. There is no combinational path from any input to any output.
- Operands are captured only at acceptance; changes on a, b or cin during RUN or DONE are ignored.
- in_valid while busy is ignored (not queued). The requester must hold in_valid until in_ready.
- Reset mid-RUN or in DONE aborts the operation, discards partial results and returns to reset values.
- WIDTH=1: RUN lasts one edge and the result equals the full-adder truth table.
- Counter width is clog2(WIDTH)+1 bits; it never wraps beyond WIDTH-1.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined: adds output port ovf (1 bit), meaning two's-complement signed overflow = carry into MSB XOR carry out of MSB.
  - Captured by registering the carry going into bit WIDTH-1 at the last RUN edge.
  - Valid and stable with out_valid; reset value 0.
- Undefined: no ovf port and no associated register; all other behaviour identical.

Decomposition:
- Shared package serial_add_pkg:
  - state enum {IDLE, RUN, DONE}
  - function computing counter width from WIDTH
  - constant MAX_WIDTH=64 used for the parameter range check
- One sub-module: fa_cell, a purely combinational 1-bit full adder (a, b, cin -> sum, cout), instantiated once.

Test Plan:
- Basic: WIDTH=8, a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0, out_valid exactly 8 edges after acceptance, in_ready=0 throughout.
- Carry chain: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum, cout and out_valid stable; in_ready=0; in_valid pulses with new operands ignored. Raising out_ready gives IDLE next cycle.
- Reset mid-op: assert rst after 3 RUN edges -> next cycle state IDLE, out_valid=0, sum=0, cout=0. The following op 0x12+0x34 yields 0x46.
- Back-to-back/randomized: 200 random a/b/cin with random out_ready -> every result matches (a+b+cin) mod 256 with cout = bit 8. Results are written to the bench's output text file for comparison against the reference model.
- With SERIAL_ADD_OVF_EN: 0x7F+0x01 -> ovf=1; 0x80+0xFF -> ovf=1, cout=1; 0x10+0x20 -> ovf=0.
